// File: rtl/prog_loader.sv
// Boot-time program loader: streams segment headers and payload words into the IM write port
// and holds the CPU in reset until a zero-length header. Optional checksum via PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int ADDR_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    output logic        IM_enable_o,
    output logic        IM_write_o,
    output logic [31:0] IM_address_o,
    output logic [31:0] IM_in_o,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [15:0]         remaining_q, remaining_d;
    logic                in_ready_q, in_ready_d;
    logic                im_wr_q, im_wr_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [31:0]         im_data_q, im_data_d;
    logic                accept;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0]         sum_q, sum_d;
`endif

    assign accept = in_valid_i && in_ready_q;

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q     <= ST_HDR;
            idx_q       <= '0;
            remaining_q <= '0;
            in_ready_q  <= 1'b0;
            im_wr_q     <= 1'b0;
            im_addr_q   <= '0;
            im_data_q   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            in_ready_q  <= in_ready_d;
            im_wr_q     <= im_wr_d;
            im_addr_q   <= im_addr_d;
            im_data_q   <= im_data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Next-state and datapath.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        im_wr_d     = 1'b0;
        im_addr_d   = im_addr_q;
        im_data_d   = im_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    if (in_data_i[15:0] == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_DATA;
                        idx_d       = ADDR_W'(in_data_i[31:16]);
                        remaining_d = in_data_i[15:0];
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_d       = '0;
`endif
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    im_wr_d     = 1'b1;
                    im_addr_d   = idx_q;
                    im_data_d   = in_data_i;
                    idx_d       = idx_q + ADDR_W'(1);
                    remaining_d = remaining_q - 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + in_data_i;
                    if (remaining_q == 16'd1) state_d = ST_CSUM;
`else
                    if (remaining_q == 16'd1) state_d = ST_HDR;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) state_d = (in_data_i == sum_q) ? ST_HDR : ST_ERROR;
            end
`endif
            default: ;
        endcase
        // Ready is registered, so it drops on the very edge that enters DONE/ERROR.
        in_ready_d = (state_d != ST_DONE) && (state_d != ST_ERROR);
    end

    // Outputs.
    always_comb begin
        in_ready_o   = in_ready_q;
        IM_enable_o  = im_wr_q;
        IM_write_o   = im_wr_q;
        IM_address_o = {{(30-ADDR_W){1'b0}}, im_addr_q, 2'b00};
        IM_in_o      = im_data_q;
        done_o       = (state_q == ST_DONE);
        cpu_rst_o    = (state_q != ST_DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
        err_o        = (state_q == ST_ERROR);
`else
        err_o        = 1'b0;
`endif
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and randomized segments checked against
// a write-list / memory-image model built from the loader's stream rules.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready;
    logic [31:0] in_data;
    logic        IM_enable, IM_write, cpu_rst, done, err;
    logic [31:0] IM_address, IM_in;

    int tests = 0;
    int fails = 0;

    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] payload[$];
    logic [31:0] model_mem[int];
    logic [31:0] seen_mem[int];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .IM_enable_o  (IM_enable),
        .IM_write_o   (IM_write),
        .IM_address_o (IM_address),
        .IM_in_o      (IM_in),
        .cpu_rst_o    (cpu_rst),
        .done_o       (done),
        .err_o        (err)
    );

    // Observed IM traffic, sampled mid-cycle.
    always @(negedge clk) begin
        if (IM_enable === 1'b1 || IM_write === 1'b1) begin
            obs_q.push_back({IM_address, IM_in});
            seen_mem[int'(IM_address >> 2)] = IM_in;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] w);
        int waitc;
        waitc    = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (in_ready !== 1'b1) check("accept_timeout", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic seg(input logic [15:0] base, input bit stall);
        logic [31:0] sum;
        logic [15:0] idx;
        sum = 32'd0;
        send({base, 16'(payload.size())});
        check("hdr_no_im", {62'd0, IM_enable, IM_write}, 64'd0);
        for (int i = 0; i < payload.size(); i++) begin
            idx = base + 16'(i);
            send(payload[i]);
            check("wr_strobe", {62'd0, IM_enable, IM_write}, 64'd3);
            check("wr_addr", {32'd0, IM_address}, {32'd0, 14'd0, idx, 2'b00});
            check("wr_data", {32'd0, IM_in}, {32'd0, payload[i]});
            exp_q.push_back({14'd0, idx, 2'b00, payload[i]});
            model_mem[int'(idx)] = payload[i];
            sum += payload[i];
            if (stall) idle();
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send(sum);
        check("csum_no_im", {62'd0, IM_enable, IM_write}, 64'd0);
`endif
    endtask

    task automatic compare_writes(input string tag);
        idle();
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check({tag, "_write"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(input int cycles);
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", {63'd0, in_ready}, 64'd1);
        check("rel_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        check("rel_done", {63'd0, done}, 64'd0);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wr_before;
        logic [15:0] base;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'd0;

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, in_ready}, 64'd0);
        check("rst_im_en", {63'd0, IM_enable}, 64'd0);
        check("rst_im_wr", {63'd0, IM_write}, 64'd0);
        check("rst_addr", {32'd0, IM_address}, 64'd0);
        check("rst_data", {32'd0, IM_in}, 64'd0);
        check("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", {63'd0, in_ready}, 64'd1);
        check("rel_cpu_rst", {63'd0, cpu_rst}, 64'd1);

        // Single segment at index 0, back-to-back payloads.
        payload = '{$urandom, $urandom, $urandom};
        seg(16'h0000, 1'b0);
        compare_writes("single");

        // Index wrap 0xFFFF -> 0x0000.
        payload = '{32'h11, 32'h22};
        seg(16'hFFFF, 1'b0);
        compare_writes("wrap");

        // in_valid toggling during payloads.
        payload = '{$urandom, $urandom, $urandom, $urandom};
        seg(16'(($urandom_range(0, 200))), 1'b1);
        compare_writes("stall");

        // Random overlapping segments.
        for (int s = 0; s < 5; s++) begin
            n = $urandom_range(1, 6);
            payload.delete();
            for (int i = 0; i < n; i++) payload.push_back($urandom);
            base = 16'($urandom_range(0, 12));
            seg(base, 1'($urandom_range(0, 1)));
            compare_writes("random");
        end

        // Terminating header.
        send(32'd0);
        check("done_flag", {63'd0, done}, 64'd1);
        check("done_cpu_rst", {63'd0, cpu_rst}, 64'd0);
        check("done_ready", {63'd0, in_ready}, 64'd0);
        check("done_err", {63'd0, err}, 64'd0);
        in_data = 32'h0000_0004;
        repeat (5) @(negedge clk);
        check("done_no_writes", 64'(obs_q.size()), 64'd0);
        check("done_sticky", {63'd0, done}, 64'd1);
        foreach (model_mem[k])
            check("mem_image", {32'd0, seen_mem.exists(k) ? seen_mem[k] : 32'hxxxx_xxxx},
                  {32'd0, model_mem[k]});

        // Reset in the middle of a segment.
        do_reset(2);
        send(32'h0100_0004);
        send($urandom);
        send($urandom);
        rst     = 1'b1;
        in_data = $urandom;
        @(negedge clk);
        check("midrst_im_en", {63'd0, IM_enable}, 64'd0);
        check("midrst_ready", {63'd0, in_ready}, 64'd0);
        check("midrst_addr", {32'd0, IM_address}, 64'd0);
        check("midrst_data", {32'd0, IM_in}, 64'd0);
        check("midrst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_writes", 64'(obs_q.size()), 64'd2);
        send(32'd0);
        check("midrst_done", {63'd0, done}, 64'd1);
        check("midrst_cpu_rel", {63'd0, cpu_rst}, 64'd0);
        idle();
        check("midrst_no_more", 64'(obs_q.size()), 64'd2);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum mismatch.
        do_reset(2);
        send(32'h0010_0002);
        send(32'd5);
        send(32'd7);
        send(32'd13);
        check("csum_err", {63'd0, err}, 64'd1);
        check("csum_ready", {63'd0, in_ready}, 64'd0);
        check("csum_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        check("csum_done", {63'd0, done}, 64'd0);
        wr_before = obs_q.size();
        in_data   = 32'h0020_0003;
        repeat (6) @(negedge clk);
        check("csum_no_writes", 64'(obs_q.size()), 64'(wr_before));
        check("csum_err_sticky", {63'd0, err}, 64'd1);
`else
        wr_before = obs_q.size();
        check("err_tied_low", {63'd0, err}, 64'd0);
        check("end_writes", 64'(obs_q.size()), 64'(wr_before));
`endif

        in_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
